// File: rtl/cam_pack_pkg.sv
// Shared types and constants for the camera line packer: read FSM states,
// header layout and the word-kind tag carried through the read pipeline.
package cam_pack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PAY  = 3'd2,
    ST_CRC  = 3'd3,
    ST_DONE = 3'd4
  } rd_state_t;

  typedef enum logic [1:0] {
    WK_HDR = 2'd0,
    WK_RAM = 2'd1,
    WK_CRC = 2'd2
  } word_kind_t;

  localparam int          HDR_WORDS     = 4;
  localparam logic [15:0] DEFAULT_MAGIC = 16'hA55A;

  localparam int HDR_IDX_MAGIC = 0;
  localparam int HDR_IDX_FRAME = 1;
  localparam int HDR_IDX_LINE  = 2;
  localparam int HDR_IDX_COUNT = 3;

endpackage

// File: rtl/line_buf_dp.sv
// Simple dual-port line RAM: one write port, one registered read port
// (read data appears one cycle after i_rd_en).
module line_buf_dp #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int W     = 16
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/cam_line_packer.sv
// Camera line packer: captures DE-framed lines into ping-pong buffers and
// emits header+payload packets on a valid/ready stream. CRC word: CAM_PACK_CRC_EN.
module cam_line_packer
  import cam_pack_pkg::*;
#(
  parameter int          H_PIXELS = 1024,
  parameter int          V_LINES  = 768,
  parameter logic [15:0] MAGIC    = DEFAULT_MAGIC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        de,
  input  logic [15:0] data_bgr565,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [15:0] drop_cnt,
  output logic        trunc_flag,
  output logic [2:0]  o_dbg_state
);

`ifdef CAM_PACK_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  localparam int CW = $clog2(H_PIXELS + 1);
  localparam int AW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int IW = (CW > 3) ? CW : 3;
  localparam logic [CW-1:0] CNT_MAX = CW'(H_PIXELS);

  // Stream handshake: a word transfers on a rising clk edge with m_valid && m_ready;
  // while m_valid=1 and m_ready=0, m_data/m_last are held unchanged.

  // ---------------- write side ----------------
  logic          r_de_d, r_vs_d, r_active, r_drop_line, r_wr_sel;
  logic [CW-1:0] r_wr_cnt;
  logic [15:0]   r_frame_id, r_line_no;
  logic [1:0]    r_full;
  logic [CW-1:0] r_cnt [2];
  logic [15:0]   r_lno [2];
  logic [15:0]   r_fid [2];

  logic          w_de_rise, w_de_fall, w_vs_rise, w_drop_now, w_in_range;
  logic          w_line_on, w_wr_en, w_mark;
  logic [CW-1:0] w_wr_pos;
  logic [1:0]    w_full_set, w_full_clr;

  assign w_de_rise  = de & ~r_de_d;
  assign w_de_fall  = ~de & r_de_d & r_active;
  assign w_vs_rise  = vsync & ~r_vs_d;
  assign w_drop_now = w_de_rise ? r_full[r_wr_sel] : r_drop_line;
  assign w_wr_pos   = w_de_rise ? '0 : r_wr_cnt;
  assign w_in_range = (w_wr_pos < CNT_MAX);
  assign w_line_on  = de & (w_de_rise | r_active) & ~w_drop_now;
  assign w_wr_en    = w_line_on & w_in_range;
  assign w_mark     = w_de_fall & ~r_drop_line & (r_wr_cnt != '0);
  assign w_full_set = {r_wr_sel & w_mark, ~r_wr_sel & w_mark};

  // Edge detectors come out of reset as "high" so a line already in progress
  // at release is ignored until the next DE rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_de_d      <= 1'b1;
      r_vs_d      <= 1'b1;
      r_active    <= 1'b0;
      r_drop_line <= 1'b0;
      r_wr_sel    <= 1'b0;
      r_wr_cnt    <= '0;
      r_frame_id  <= '0;
      r_line_no   <= '0;
      drop_cnt    <= '0;
      trunc_flag  <= 1'b0;
      r_full      <= 2'b00;
    end else begin
      r_de_d <= de;
      r_vs_d <= vsync;
      if (w_de_rise) begin
        r_active    <= 1'b1;
        r_drop_line <= r_full[r_wr_sel];
        if (r_full[r_wr_sel] && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (w_de_fall) begin
        r_active    <= 1'b0;
        r_drop_line <= 1'b0;
        if (w_mark) r_wr_sel <= ~r_wr_sel;
      end
      if (w_line_on) begin
        if (w_in_range) r_wr_cnt <= w_wr_pos + CW'(1);
        else            trunc_flag <= 1'b1;
      end
      if (w_vs_rise) begin
        r_frame_id <= r_frame_id + 16'd1;
        r_line_no  <= '0;
      end else if (w_de_fall) begin
        r_line_no <= (r_line_no == 16'(V_LINES - 1)) ? '0 : r_line_no + 16'd1;
      end
      r_full <= (r_full & ~w_full_clr) | w_full_set;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (w_full_set[b]) begin
        r_cnt[b] <= r_wr_cnt;
        r_lno[b] <= r_line_no;
        r_fid[b] <= r_frame_id;
      end
    end
  end

  // ---------------- read side ----------------
  rd_state_t   r_state, w_next;
  logic        r_rd_sel;
  logic [IW-1:0] r_idx;
  logic [15:0] r_sum;
  logic        r_p_valid, r_p_last, r_p_sel;
  word_kind_t  r_p_kind;
  logic [15:0] r_p_hdr;
  logic [15:0] r_q_data [2];
  logic        r_q_last [2];
  logic [1:0]  r_q_cnt;
  logic        r_q_head;

  logic        w_pop, w_push, w_can_issue, w_issue, w_iss_last, w_last_pix, w_q_wr;
  word_kind_t  w_iss_kind;
  logic [15:0] w_hdr_word, w_stage_data;
  logic [15:0] w_rd_data [2];
  logic [CW-1:0] w_cur_cnt;

  assign w_pop       = m_valid & m_ready;
  assign w_push      = r_p_valid;
  assign w_q_wr      = r_q_head ^ r_q_cnt[0];
  assign w_cur_cnt   = r_cnt[r_rd_sel];
  assign w_last_pix  = (r_idx == IW'(w_cur_cnt) - IW'(1));
  // Count words already queued or in the RAM-latency stage; keeps the
  // 2-entry skid from overflowing while still sustaining one word per cycle.
  assign w_can_issue = ({1'b0, r_q_cnt} + {2'b00, r_p_valid}) < (3'd2 + {2'b00, w_pop});

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (r_full[r_rd_sel]) w_next = ST_HDR;
      ST_HDR:  if (w_can_issue && r_idx == IW'(HDR_WORDS - 1)) w_next = ST_PAY;
      ST_PAY:  if (w_can_issue && w_last_pix) w_next = CRC_EN ? ST_CRC : ST_DONE;
      ST_CRC:  if (w_can_issue) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_issue    = 1'b0;
    w_iss_kind = WK_HDR;
    w_iss_last = 1'b0;
    w_full_clr = 2'b00;
    unique case (r_state)
      ST_HDR: w_issue = w_can_issue;
      ST_PAY: begin
        w_issue    = w_can_issue;
        w_iss_kind = WK_RAM;
        w_iss_last = w_last_pix & ~CRC_EN;
      end
      ST_CRC: begin
        w_issue    = w_can_issue;
        w_iss_kind = WK_CRC;
        w_iss_last = 1'b1;
      end
      ST_DONE: w_full_clr = {r_rd_sel, ~r_rd_sel};
      default: ;
    endcase
  end

  always_comb begin
    w_hdr_word = MAGIC;
    if (r_idx == IW'(HDR_IDX_FRAME))      w_hdr_word = r_fid[r_rd_sel];
    else if (r_idx == IW'(HDR_IDX_LINE))  w_hdr_word = r_lno[r_rd_sel];
    else if (r_idx == IW'(HDR_IDX_COUNT)) w_hdr_word = 16'(w_cur_cnt);
  end

  always_comb begin
    w_stage_data = r_p_hdr;
    if (r_p_kind == WK_RAM)      w_stage_data = w_rd_data[r_p_sel];
    else if (r_p_kind == WK_CRC) w_stage_data = r_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_rd_sel    <= 1'b0;
      r_sum       <= '0;
      r_p_valid   <= 1'b0;
      r_p_last    <= 1'b0;
      r_p_sel     <= 1'b0;
      r_p_kind    <= WK_HDR;
      r_p_hdr     <= '0;
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
      r_q_last[0] <= 1'b0;
      r_q_last[1] <= 1'b0;
      r_q_cnt     <= '0;
      r_q_head    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_idx <= '0;
        r_sum <= '0;
      end else if (w_issue) begin
        r_idx <= (r_state == ST_HDR && r_idx == IW'(HDR_WORDS - 1)) ? '0 : r_idx + IW'(1);
      end
      if (r_state == ST_DONE) r_rd_sel <= ~r_rd_sel;
      r_p_valid <= w_issue;
      if (w_issue) begin
        r_p_kind <= w_iss_kind;
        r_p_last <= w_iss_last;
        r_p_hdr  <= w_hdr_word;
        r_p_sel  <= r_rd_sel;
      end
      if (w_push && r_p_kind == WK_RAM) r_sum <= r_sum + w_stage_data;
      if (w_push) begin
        r_q_data[w_q_wr] <= w_stage_data;
        r_q_last[w_q_wr] <= r_p_last;
      end
      if (w_pop) r_q_head <= ~r_q_head;
      r_q_cnt <= r_q_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  line_buf_dp #(.DEPTH(H_PIXELS), .AW(AW), .W(16)) u_buf0 (
    .clk       (clk),
    .i_wr_en   (w_wr_en & ~r_wr_sel),
    .i_wr_addr (w_wr_pos[AW-1:0]),
    .i_wr_data (data_bgr565),
    .i_rd_en   (w_issue & (w_iss_kind == WK_RAM) & ~r_rd_sel),
    .i_rd_addr (r_idx[AW-1:0]),
    .o_rd_data (w_rd_data[0])
  );

  line_buf_dp #(.DEPTH(H_PIXELS), .AW(AW), .W(16)) u_buf1 (
    .clk       (clk),
    .i_wr_en   (w_wr_en & r_wr_sel),
    .i_wr_addr (w_wr_pos[AW-1:0]),
    .i_wr_data (data_bgr565),
    .i_rd_en   (w_issue & (w_iss_kind == WK_RAM) & r_rd_sel),
    .i_rd_addr (r_idx[AW-1:0]),
    .o_rd_data (w_rd_data[1])
  );

  assign m_valid     = (r_q_cnt != 2'd0);
  assign m_data      = r_q_data[r_q_head];
  assign m_last      = r_q_last[r_q_head] & m_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cam_line_packer.sv
// Self-checking bench for cam_line_packer (H_PIXELS=8): expected packet words
// are queued as lines are driven and compared as the stream hands them over.
module tb_cam_line_packer;
  import cam_pack_pkg::*;

`ifdef CAM_PACK_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic        de = 1'b0;
  logic [15:0] data_bgr565 = '0;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic [15:0] drop_cnt;
  logic        trunc_flag;
  logic [2:0]  o_dbg_state;

  int n_chk  = 0;
  int n_fail = 0;
  int rdy_mode = 0;

  logic [16:0] exp_q[$];
  logic [15:0] px [16];
  logic        stall_prev = 1'b0;
  logic [15:0] held_data;
  logic        held_last;

  cam_line_packer #(.H_PIXELS(8), .V_LINES(768), .MAGIC(16'hA55A)) dut (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync),
    .de          (de),
    .data_bgr565 (data_bgr565),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .drop_cnt    (drop_cnt),
    .trunc_flag  (trunc_flag),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      2:       m_ready = 1'b0;
      default: m_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic drive_line(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      de = 1'b1;
      data_bgr565 = px[i];
    end
    @(posedge clk); #1;
    de = 1'b0;
    data_bgr565 = '0;
    repeat (3) @(posedge clk);
  endtask

  task automatic pulse_vsync();
    @(posedge clk); #1; vsync = 1'b1;
    @(posedge clk); #1; vsync = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic fill_px(input logic [15:0] base, input bit rnd);
    for (int i = 0; i < 16; i++)
      px[i] = rnd ? 16'($urandom_range(0, 65535)) : base + 16'(i);
  endtask

  task automatic push_packet(input logic [15:0] fid, input logic [15:0] lno, input int cnt);
    logic [15:0] sum;
    sum = '0;
    exp_q.push_back({1'b0, 16'hA55A});
    exp_q.push_back({1'b0, fid});
    exp_q.push_back({1'b0, lno});
    exp_q.push_back({1'b0, 16'(cnt)});
    for (int i = 0; i < cnt; i++) begin
      sum = sum + px[i];
      exp_q.push_back({(i == cnt - 1) && !CRC_ON, px[i]});
    end
    if (CRC_ON) exp_q.push_back({1'b1, sum});
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_valid) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("stall_valid", {31'd0, m_valid}, 1);
        check_eq("stall_data", {16'd0, m_data}, {16'd0, held_data});
        check_eq("stall_last", {31'd0, m_last}, {31'd0, held_last});
      end
      if (m_valid && m_ready) begin
        check_eq("word_expected", {31'd0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("m_data", {16'd0, m_data}, {16'd0, e[15:0]});
          check_eq("m_last", {31'd0, m_last}, {31'd0, e[16]});
        end
      end
      stall_prev = m_valid && !m_ready;
      held_data  = m_data;
      held_last  = m_last;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_m_valid", {31'd0, m_valid}, 0);
    check_eq("rst_m_last", {31'd0, m_last}, 0);
    check_eq("rst_m_data", {16'd0, m_data}, 0);
    check_eq("rst_drop_cnt", {16'd0, drop_cnt}, 0);
    check_eq("rst_trunc", {31'd0, trunc_flag}, 0);
    check_eq("rst_state", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});

    // basic line 0x0001..0x0008
    rdy_mode = 0;
    fill_px(16'h0001, 1'b0);
    push_packet(16'd0, 16'd0, 8);
    drive_line(8);
    wait_drain("basic", 200);

    // same line under alternating backpressure
    do_reset();
    rdy_mode = 1;
    push_packet(16'd0, 16'd0, 8);
    drive_line(8);
    wait_drain("backpressure", 300);

    // overflow: three lines with the sink stalled
    do_reset();
    rdy_mode = 2;
    for (int l = 0; l < 3; l++) begin
      fill_px(16'(16'h0100 * (l + 1)), 1'b0);
      if (l < 2) push_packet(16'd0, 16'(l), 8);
      drive_line(8);
    end
    repeat (4) @(negedge clk);
    check_eq("ovf_drop_cnt", {16'd0, drop_cnt}, 1);
    check_eq("ovf_valid_held", {31'd0, m_valid}, 1);
    rdy_mode = 0;
    wait_drain("overflow", 300);
    check_eq("ovf_drop_cnt_after", {16'd0, drop_cnt}, 1);

    // truncation: 10 pixels into an 8-pixel buffer
    do_reset();
    rdy_mode = 3;
    fill_px(16'h0000, 1'b1);
    push_packet(16'd0, 16'd0, 8);
    drive_line(10);
    wait_drain("trunc", 300);
    check_eq("trunc_flag", {31'd0, trunc_flag}, 1);

    // frame rollover between lines
    fill_px(16'h0000, 1'b1);
    push_packet(16'd0, 16'd1, 5);
    drive_line(5);
    pulse_vsync();
    fill_px(16'h0000, 1'b1);
    push_packet(16'd1, 16'd0, 8);
    drive_line(8);
    wait_drain("frame", 400);

    // reset during payload, then a clean packet
    rdy_mode = 0;
    pulse_vsync();
    fill_px(16'h0000, 1'b1);
    push_packet(16'd2, 16'd0, 8);
    drive_line(8);
    k = 0;
    while (o_dbg_state != ST_PAY && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("reached_pay", {29'd0, o_dbg_state}, {29'd0, ST_PAY});
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_m_valid", {31'd0, m_valid}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("midrst_drop_cnt", {16'd0, drop_cnt}, 0);
    check_eq("midrst_trunc", {31'd0, trunc_flag}, 0);
    check_eq("midrst_state", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
    fill_px(16'h0000, 1'b1);
    push_packet(16'd0, 16'd0, 8);
    rdy_mode = 3;
    drive_line(8);
    wait_drain("post_reset", 300);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
